// File: rtl/codec_pkg.sv
// Shared definitions for the codec ADC-side serial transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default sample width and buffer depth, transmitter FSM state
// encoding, and a saturating 8-bit increment used by the underrun counter.
package codec_pkg;

  localparam int CODEC_DATA_W     = 16;
  localparam int CODEC_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } adc_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Generic synchronous FIFO holding one stereo pair per entry.
// Latency: a pushed word is visible on pop_dat one clock after the push.
// Backpressure: push is dropped when full, pop is ignored when empty.
//
// Ports:
//   clk      - clock, state updates on the falling edge
//   rst_n    - asynchronous active-low reset (empties the FIFO)
//   push     - write push_dat this edge
//   push_dat - WIDTH-bit word to write
//   pop      - retire the head entry this edge
//   pop_dat  - head entry (combinational read of the storage)
//   level    - number of entries currently held, 0..DEPTH
module pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && (level_q != LVL_MAX);
  assign pop_ok  = pop && (level_q != '0);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter gates every read that matters.
  always_ff @(negedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/codec_adc_tx.sv
// Buffers stereo sample pairs and serialises them left-justified onto AUD_ADCDAT.
// Latency: MSB of a slot appears on the same BCLK falling edge that sees the LRCK change.
// Backpressure: s_ready drops while the pair buffer is full; an empty buffer sends a zero frame.
//
// Ports:
//   AUD_BCLK     - bit clock, all state updates on its falling edge
//   AUD_DACLRCK  - asynchronous active-low reset
//   AUD_ADCLRCK  - frame clock, high = left slot, low = right slot
//   s_valid/s_ready, s_left/s_right - pair input handshake and samples
//   AUD_ADCDAT   - registered serial data, MSB first
//   underrun_cnt - saturating count of frames sent without buffered data
//   fifo_level   - pairs currently buffered
module codec_adc_tx
  import codec_pkg::*;
#(
  parameter int DATA_W     = CODEC_DATA_W,
  parameter int FIFO_DEPTH = CODEC_FIFO_DEPTH
) (
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  input  logic                          AUD_ADCLRCK,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  output logic                          AUD_ADCDAT,
  output logic [7:0]                    underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  adc_state_e        state_q, state_d;
  logic              lrck_q, lrck_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d;
  logic [DATA_W-1:0] sh_r_q, sh_r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              adcdat_q, adcdat_d;
  logic [7:0]        urun_q, urun_d;

  pair_t             push_pair, pop_pair, load_pair;
  logic              push, pop;
  logic [LW-1:0]     level;
  logic              lrck_rise, lrck_fall;
  logic              enter_left, enter_right;

  assign push_pair = '{left: s_left, right: s_right};

  // Ready depends only on the registered level, never on the same-edge pop.
  assign s_ready = (level != LVL_FULL);
  assign push    = s_valid & s_ready;

  // lrck_q holds the frame clock as seen on the previous falling edge.
  assign lrck_d    = AUD_ADCLRCK;
  assign lrck_rise =  AUD_ADCLRCK & ~lrck_q;
  assign lrck_fall = ~AUD_ADCLRCK &  lrck_q;

  assign enter_left  = lrck_rise && ((state_q == ST_IDLE) || (state_q == ST_RIGHT));
  assign enter_right = lrck_fall && (state_q == ST_LEFT);

  // Pop decision uses the pre-edge level, so a pair pushed on this very edge
  // cannot be forwarded and the frame counts as an underrun.
  assign pop = enter_left && (level != '0);

  pair_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (AUD_BCLK),
    .rst_n    (AUD_DACLRCK),
    .push     (push),
    .push_dat (push_pair),
    .pop      (pop),
    .pop_dat  (pop_pair),
    .level    (level)
  );

  always_comb begin
    state_d   = state_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    cnt_d     = cnt_q;
    adcdat_d  = 1'b0;
    urun_d    = urun_q;
    load_pair = '0;

    if (enter_left) begin
      state_d = ST_LEFT;
      if (pop) begin
        load_pair = pop_pair;
      end else begin
        urun_d = sat_inc8(urun_q);
      end
      // MSB goes straight to the output register; the shifter keeps the rest.
      adcdat_d = load_pair.left[DATA_W-1];
      sh_l_d   = {load_pair.left[DATA_W-2:0], 1'b0};
      sh_r_d   = load_pair.right;
      cnt_d    = CNT_LOAD;
    end else if (enter_right) begin
      // Any unsent left bits are abandoned; right sample was parked untouched.
      state_d  = ST_RIGHT;
      adcdat_d = sh_r_q[DATA_W-1];
      sh_r_d   = {sh_r_q[DATA_W-2:0], 1'b0};
      cnt_d    = CNT_LOAD;
    end else if (cnt_q != '0) begin
      // cnt_q counts bits still to send in this slot; it sticks at zero.
      cnt_d = cnt_q - CNT_ONE;
      if (state_q == ST_LEFT) begin
        adcdat_d = sh_l_q[DATA_W-1];
        sh_l_d   = {sh_l_q[DATA_W-2:0], 1'b0};
      end else if (state_q == ST_RIGHT) begin
        adcdat_d = sh_r_q[DATA_W-1];
        sh_r_d   = {sh_r_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge AUD_BCLK or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      state_q  <= ST_IDLE;
      lrck_q   <= 1'b0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      cnt_q    <= '0;
      adcdat_q <= 1'b0;
      urun_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      lrck_q   <= lrck_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      cnt_q    <= cnt_d;
      adcdat_q <= adcdat_d;
      urun_q   <= urun_d;
    end
  end

  assign AUD_ADCDAT   = adcdat_q;
  assign underrun_cnt = urun_q;
  assign fifo_level   = level;

endmodule

// File: tb/tb_codec_adc_tx.sv
// Directed bench for codec_adc_tx with hand-computed serial words.
// Latency: outputs sampled 2 time units after each BCLK falling edge.
// Backpressure: exercises full-buffer stall and empty-buffer underrun.
module tb_codec_adc_tx;

  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_ADCLRCK;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        AUD_ADCDAT;
  logic [7:0]  underrun_cnt;
  logic [2:0]  fifo_level;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap;

  logic [15:0] tl [5];
  logic [15:0] tr [5];

  codec_adc_tx #(
    .DATA_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_left       (s_left),
    .s_right      (s_right),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level)
  );

  initial AUD_BCLK = 1'b1;
  always #5 AUD_BCLK = ~AUD_BCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One falling BCLK edge; returns in the low phase, away from the edge.
  task automatic step();
    @(negedge AUD_BCLK);
    #2;
  endtask

  task automatic grab(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cap = {cap[30:0], AUD_ADCDAT};
    end
  endtask

  task automatic slot(input logic lr, input int n);
    cap = 32'd0;
    AUD_ADCLRCK = lr;
    grab(n);
  endtask

  task automatic push_one(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    AUD_DACLRCK = 1'b0;
    AUD_ADCLRCK = 1'b0;
    s_valid     = 1'b0;
    s_left      = 16'd0;
    s_right     = 16'd0;
    cap         = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tl[i] = 16'h1111 * 16'(i + 1);
      tr[i] = ~tl[i];
    end

    // Reset state
    step(); step(); step();
    check("rst_adcdat", 32'(AUD_ADCDAT), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_urun", 32'(underrun_cnt), 32'd0);
    AUD_DACLRCK = 1'b1;
    step(); step();
    check("idle_adcdat", 32'(AUD_ADCDAT), 32'd0);

    // Basic frame, 32 BCLK per slot
    push_one(16'hA5C3, 16'h0F0F);
    check("t1_level_push", 32'(fifo_level), 32'd1);
    slot(1'b1, 32);
    check("t1_left", cap, 32'hA5C3_0000);
    check("t1_level_pop", 32'(fifo_level), 32'd0);
    slot(1'b0, 32);
    check("t1_right", cap, 32'h0F0F_0000);
    check("t1_urun", 32'(underrun_cnt), 32'd0);

    // Push into empty FIFO on the left-entry edge: no bypass
    s_valid = 1'b1;
    s_left  = 16'h8001;
    s_right = 16'h7FFE;
    cap = 32'd0;
    AUD_ADCLRCK = 1'b1;
    grab(1);
    s_valid = 1'b0;
    check("t5_level", 32'(fifo_level), 32'd1);
    check("t5_urun", 32'(underrun_cnt), 32'd1);
    grab(31);
    check("t5_left_zero", cap, 32'd0);
    slot(1'b0, 32);
    check("t5_right_zero", cap, 32'd0);
    slot(1'b1, 32);
    check("t5_left_next", cap, 32'h8001_0000);
    slot(1'b0, 32);
    check("t5_right_next", cap, 32'h7FFE_0000);
    check("t5_urun_hold", 32'(underrun_cnt), 32'd1);

    // Starvation and saturation of the underrun counter
    for (int f = 0; f < 3; f++) begin
      slot(1'b1, 32);
      check("t2_left_zero", cap, 32'd0);
      slot(1'b0, 32);
      check("t2_right_zero", cap, 32'd0);
    end
    check("t2_urun4", 32'(underrun_cnt), 32'd4);
    for (int f = 0; f < 251; f++) begin
      slot(1'b1, 4);
      slot(1'b0, 4);
    end
    check("t2_urun255", 32'(underrun_cnt), 32'd255);
    for (int f = 0; f < 48; f++) begin
      slot(1'b1, 4);
      slot(1'b0, 4);
    end
    check("t2_urun_sat", 32'(underrun_cnt), 32'd255);

    // Fill to full, stall, then release by the first pop
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_left  = tl[i];
      s_right = tr[i];
      step();
      if (i == 2) check("t3_ready_3", 32'(s_ready), 32'd1);
    end
    check("t3_ready_full", 32'(s_ready), 32'd0);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    s_left  = tl[4];
    s_right = tr[4];
    step();
    check("t3_level_stall", 32'(fifo_level), 32'd4);
    cap = 32'd0;
    AUD_ADCLRCK = 1'b1;
    grab(1);
    check("t3_level_pop", 32'(fifo_level), 32'd3);
    check("t3_ready_pop", 32'(s_ready), 32'd1);
    grab(1);
    s_valid = 1'b0;
    check("t3_level_5th", 32'(fifo_level), 32'd4);
    grab(30);
    check("t3_left0", cap, {tl[0], 16'h0000});
    slot(1'b0, 32);
    check("t3_right0", cap, {tr[0], 16'h0000});
    for (int i = 1; i < 5; i++) begin
      slot(1'b1, 32);
      check("t3_left_n", cap, {tl[i], 16'h0000});
      slot(1'b0, 32);
      check("t3_right_n", cap, {tr[i], 16'h0000});
    end
    check("t3_level_end", 32'(fifo_level), 32'd0);

    // Shortened left slot of 10 BCLK
    push_one(16'hB6D9, 16'h3C5A);
    slot(1'b1, 10);
    check("t4_short_left", cap, 32'h0000_02DB);
    slot(1'b0, 16);
    check("t4_right_msb", cap, 32'h0000_3C5A);

    // Reset in the middle of the left slot
    push_one(16'hFFFF, 16'hFFFF);
    push_one(16'h1357, 16'h2468);
    check("t6_level_pre", 32'(fifo_level), 32'd2);
    slot(1'b1, 9);
    check("t6_bits_pre", cap, 32'h0000_01FF);
    check("t6_bit7", 32'(AUD_ADCDAT), 32'd1);
    check("t6_level_mid", 32'(fifo_level), 32'd1);
    AUD_DACLRCK = 1'b0;
    #1;
    check("t6_rst_adcdat", 32'(AUD_ADCDAT), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_ready", 32'(s_ready), 32'd1);
    check("t6_rst_urun", 32'(underrun_cnt), 32'd0);
    step(); step();
    AUD_ADCLRCK = 1'b0;
    step(); step();
    AUD_DACLRCK = 1'b1;
    cap = 32'd0;
    grab(8);
    check("t6_quiet", cap, 32'd0);
    push_one(16'h1234, 16'h5678);
    slot(1'b1, 32);
    check("t6_left_after", cap, 32'h1234_0000);
    slot(1'b0, 32);
    check("t6_right_after", cap, 32'h5678_0000);
    check("t6_urun_after", 32'(underrun_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
